// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit:
// opcodes, FSM states and datapath mux selects.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
      S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK, S_TRAP
   } state_t;

   localparam logic [1:0] ALU_A_PC    = 2'b00;
   localparam logic [1:0] ALU_A_OLDPC = 2'b01;
   localparam logic [1:0] ALU_A_RS1   = 2'b10;

   localparam logic [1:0] ALU_B_RS2   = 2'b00;
   localparam logic [1:0] ALU_B_IMM   = 2'b01;
   localparam logic [1:0] ALU_B_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/ctrl_next_state.sv
// Combinational next-state and Moore output decode for the multicycle control FSM.
module ctrl_next_state
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 7
) (
   input  state_t              state,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   input  logic                timeout,
   output state_t              state_nxt,
   output logic                mem_req,
   output logic                mem_we,
   output logic                adr_src,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          result_src,
   output logic                reg_write,
   output logic                retire,
   output logic                set_illegal,
   output logic                set_bus_error
);

   always_comb begin
      state_nxt     = state;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      alu_src_a     = '0;
      alu_src_b     = '0;
      alu_op        = '0;
      result_src    = '0;
      reg_write     = 1'b0;
      retire        = 1'b0;
      set_illegal   = 1'b0;
      set_bus_error = 1'b0;

      case (state)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = ALU_A_PC;
            alu_src_b  = ALU_B_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_nxt = S_DECODE;
            else if (timeout) begin
               state_nxt     = S_TRAP;
               set_bus_error = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_a = ALU_A_OLDPC;
            alu_src_b = ALU_B_IMM;
            alu_op    = ALUOP_ADD;
            if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) state_nxt = S_MEMADR;
            else if (opcode == OPCODE_W'(OP_R))    state_nxt = S_EXEC_R;
            else if (opcode == OPCODE_W'(OP_I))    state_nxt = S_EXEC_I;
            else if (opcode == OPCODE_W'(OP_BR))   state_nxt = S_BRANCH;
            else if (opcode == OPCODE_W'(OP_JAL))  state_nxt = S_JAL;
            else if (opcode == OPCODE_W'(OP_JALR)) state_nxt = S_JALR;
            else begin
               state_nxt   = S_TRAP;
               set_illegal = 1'b1;
            end
         end
         S_MEMADR: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_IMM;
            alu_op    = ALUOP_ADD;
            state_nxt = (opcode == OPCODE_W'(OP_LW)) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_nxt = S_MEMWB;
            else if (timeout) begin
               state_nxt     = S_TRAP;
               set_bus_error = 1'b1;
            end
         end
         S_MEMWB: begin
            result_src = RES_MEM;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               state_nxt = S_FETCH;
               retire    = 1'b1;
            end else if (timeout) begin
               state_nxt     = S_TRAP;
               set_bus_error = 1'b1;
            end
         end
         S_EXEC_R: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_RS2;
            alu_op    = ALUOP_RTYPE;
            state_nxt = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_IMM;
            alu_op    = ALUOP_ITYPE;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = ALU_A_RS1;
            alu_src_b  = ALU_B_RS2;
            alu_op     = ALUOP_BRANCH;
            result_src = RES_ALUOUT;
            pc_write   = zero;
            retire     = 1'b1;
            state_nxt  = S_FETCH;
         end
         // JAL retires through ALUWB, which writes the oldPC+4 link value
         S_JAL: begin
            alu_src_a  = ALU_A_OLDPC;
            alu_src_b  = ALU_B_FOUR;
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
            state_nxt  = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a  = ALU_A_RS1;
            alu_src_b  = ALU_B_IMM;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALU;
            pc_write   = 1'b1;
            state_nxt  = S_JALR_LINK;
         end
         S_JALR_LINK: begin
            alu_src_a  = ALU_A_OLDPC;
            alu_src_b  = ALU_B_FOUR;
            result_src = RES_ALU;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_FETCH;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: state register, memory wait counter,
// sticky trap flags and retired-instruction counter around ctrl_next_state.
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 7,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                adr_src,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          result_src,
   output logic                reg_write,
   output logic [CNT_W-1:0]    retired,
   output logic                illegal,
   output logic                bus_error
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t              state, state_nxt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                waiting, timeout;
   logic                retire, set_illegal, set_bus_error;

   assign waiting = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
   assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   ctrl_next_state #(.OPCODE_W(OPCODE_W)) u_next (
      .state         (state),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .timeout       (timeout),
      .state_nxt     (state_nxt),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .adr_src       (adr_src),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .result_src    (result_src),
      .reg_write     (reg_write),
      .retire        (retire),
      .set_illegal   (set_illegal),
      .set_bus_error (set_bus_error)
   );

   // Clearing on every transition equals clearing on entry to the wait states:
   // the count is only looked at while sitting in one of them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         wait_cnt  <= '0;
         retired   <= '0;
         illegal   <= 1'b0;
         bus_error <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) wait_cnt <= '0;
         else if (waiting)       wait_cnt <= wait_cnt + 1'b1;
         if (retire)        retired   <= retired + 1'b1;
         if (set_illegal)   illegal   <= 1'b1;
         if (set_bus_error) bus_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words
// are queued as stimulus is driven and compared against negedge samples.
`timescale 1ns/1ps
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n, zero, mem_ready;
   logic [6:0]  opcode;
   logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
   logic [31:0] retired;
   logic        illegal, bus_error;

   multicycle_control #(.OPCODE_W(7), .CNT_W(32), .MEM_TIMEOUT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .result_src (result_src),
      .reg_write  (reg_write),
      .retired    (retired),
      .illegal    (illegal),
      .bus_error  (bus_error)
   );

   always #5 clk = ~clk;

   typedef enum int {
      B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMWB, B_MEMWRITE, B_EXEC_R,
      B_EXEC_I, B_ALUWB, B_BRANCH, B_JAL, B_JALR, B_JALR_LINK, B_TRAP
   } bstate_e;

   // ctl = {mem_req, mem_we, adr_src, ir_write, pc_write, A, B, alu_op, result_src, reg_write}
   typedef struct packed {
      logic [13:0] ctl;
      logic [31:0] ret;
      logic        ill;
      logic        be;
   } obs_t;

   obs_t        exp_q[$];
   obs_t        obs_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_ret;
   logic        exp_ill, exp_be;
   bit          mon_en = 1'b0;

   always @(negedge clk)
      if (mon_en)
         obs_q.push_back({mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
                          alu_op, result_src, reg_write, retired, illegal, bus_error});

   function automatic logic [13:0] ctl_of(bstate_e s, logic rdy, logic z);
      case (s)
         B_FETCH:     return {1'b1, 1'b0, 1'b0, rdy, rdy, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
         B_DECODE:    return {5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
         B_MEMADR:    return {5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
         B_MEMREAD:   return {5'b10100, 8'b0, 1'b0};
         B_MEMWB:     return {5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1};
         B_MEMWRITE:  return {5'b11100, 9'b0};
         B_EXEC_R:    return {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
         B_EXEC_I:    return {5'b00000, 2'b10, 2'b01, 2'b11, 2'b00, 1'b0};
         B_ALUWB:     return {5'b00000, 8'b0, 1'b1};
         B_BRANCH:    return {4'b0000, z, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
         B_JAL:       return {4'b0000, 1'b1, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
         B_JALR:      return {4'b0000, 1'b1, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
         B_JALR_LINK: return {5'b00000, 2'b01, 2'b10, 2'b00, 2'b10, 1'b1};
         default:     return '0;
      endcase
   endfunction

   // One clock of stimulus; the expected sample for this cycle goes to the scoreboard.
   task automatic go(input bstate_e s, input logic rdy, input logic z);
      mem_ready = rdy;
      zero      = z;
      exp_q.push_back({ctl_of(s, rdy, z), exp_ret, exp_ill, exp_be});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      obs_t e, o;
      mon_en = 1'b1;
      go(B_FETCH, 1'b0, 1'b0);
      go(B_FETCH, 1'b0, 1'b0);
      rst_n  = 1'b1;
      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL reset: ctl=%b ret=%0d ill=%b be=%b required ctl=%b ret=%0d ill=%b be=%b",
                     o.ctl, o.ret, o.ill, o.be, e.ctl, e.ret, e.ill, e.be);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_rtype;
      obs_t e, o;
      opcode = 7'b0110011;
      mon_en = 1'b1;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_EXEC_R, 1'b0, 1'b0);
      go(B_ALUWB, 1'b0, 1'b0);
      exp_ret++;
      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL rtype: ctl=%b ret=%0d ill=%b be=%b required ctl=%b ret=%0d ill=%b be=%b",
                     o.ctl, o.ret, o.ill, o.be, e.ctl, e.ret, e.ill, e.be);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_lw_wait;
      obs_t e, o;
      opcode = 7'b0000011;
      mon_en = 1'b1;
      go(B_FETCH, 1'b0, 1'b0);
      go(B_FETCH, 1'b0, 1'b0);
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_MEMADR, 1'b0, 1'b0);
      go(B_MEMREAD, 1'b0, 1'b0);
      go(B_MEMREAD, 1'b0, 1'b0);
      go(B_MEMREAD, 1'b1, 1'b0);
      go(B_MEMWB, 1'b0, 1'b0);
      exp_ret++;
      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL lw_wait: ctl=%b ret=%0d ill=%b be=%b required ctl=%b ret=%0d ill=%b be=%b",
                     o.ctl, o.ret, o.ill, o.be, e.ctl, e.ret, e.ill, e.be);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_branch;
      obs_t e, o;
      opcode = 7'b1100011;
      mon_en = 1'b1;
      go(B_FETCH, 1'b1, 1'b1);
      go(B_DECODE, 1'b0, 1'b1);
      go(B_BRANCH, 1'b0, 1'b1);
      exp_ret++;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_BRANCH, 1'b0, 1'b0);
      exp_ret++;
      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL branch: ctl=%b ret=%0d ill=%b be=%b required ctl=%b ret=%0d ill=%b be=%b",
                     o.ctl, o.ret, o.ill, o.be, e.ctl, e.ret, e.ill, e.be);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_jumps_itype_sw;
      obs_t e, o;
      mon_en = 1'b1;
      opcode = 7'b1100111;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_JALR, 1'b0, 1'b0);
      go(B_JALR_LINK, 1'b0, 1'b0);
      exp_ret++;
      opcode = 7'b1101111;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_JAL, 1'b0, 1'b0);
      go(B_ALUWB, 1'b0, 1'b0);
      exp_ret++;
      opcode = 7'b0010011;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_EXEC_I, 1'b0, 1'b0);
      go(B_ALUWB, 1'b0, 1'b0);
      exp_ret++;
      opcode = 7'b0100011;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_MEMADR, 1'b0, 1'b0);
      go(B_MEMWRITE, 1'b1, 1'b0);
      exp_ret++;
      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL jumps_itype_sw: ctl=%b ret=%0d ill=%b be=%b required ctl=%b ret=%0d ill=%b be=%b",
                     o.ctl, o.ret, o.ill, o.be, e.ctl, e.ret, e.ill, e.be);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_illegal;
      obs_t e, o;
      opcode = 7'b0000000;
      mon_en = 1'b1;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      exp_ill = 1'b1;
      for (int i = 0; i < 20; i++) go(B_TRAP, i[0], 1'b1);
      rst_n   = 1'b0;
      exp_ret = '0;
      exp_ill = 1'b0;
      go(B_FETCH, 1'b0, 1'b0);
      rst_n  = 1'b1;
      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL illegal: ctl=%b ret=%0d ill=%b be=%b required ctl=%b ret=%0d ill=%b be=%b",
                     o.ctl, o.ret, o.ill, o.be, e.ctl, e.ret, e.ill, e.be);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_timeout;
      obs_t e, o;
      opcode = 7'b0100011;
      mon_en = 1'b1;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_MEMADR, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) go(B_MEMWRITE, 1'b0, 1'b0);
      exp_be = 1'b1;
      for (int i = 0; i < 3; i++) go(B_TRAP, 1'b1, 1'b0);
      rst_n   = 1'b0;
      exp_ret = '0;
      exp_be  = 1'b0;
      go(B_FETCH, 1'b0, 1'b0);
      rst_n = 1'b1;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_MEMADR, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) go(B_MEMWRITE, 1'b0, 1'b0);
      go(B_MEMWRITE, 1'b1, 1'b0);
      exp_ret++;
      go(B_FETCH, 1'b0, 1'b0);
      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL timeout: ctl=%b ret=%0d ill=%b be=%b required ctl=%b ret=%0d ill=%b be=%b",
                     o.ctl, o.ret, o.ill, o.be, e.ctl, e.ret, e.ill, e.be);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_reset_mid_access;
      obs_t e, o;
      opcode = 7'b0000011;
      mon_en = 1'b1;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_MEMADR, 1'b0, 1'b0);
      mem_ready = 1'b0;
      #1;
      checks++;
      if ({mem_req, adr_src, retired} !== {2'b11, exp_ret}) begin
         failures++;
         $display("FAIL memread_before_reset: req/adr/ret=%b/%b/%0d required 1/1/%0d",
                  mem_req, adr_src, retired, exp_ret);
      end
      rst_n   = 1'b0;
      exp_ret = '0;
      exp_q.push_back({ctl_of(B_FETCH, 1'b0, 1'b0), exp_ret, exp_ill, exp_be});
      #1;
      checks++;
      if ({adr_src, retired} !== {1'b0, 32'd0}) begin
         failures++;
         $display("FAIL async_reset: adr_src/ret=%b/%0d required 0/0", adr_src, retired);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      go(B_FETCH, 1'b1, 1'b0);
      go(B_DECODE, 1'b0, 1'b0);
      go(B_MEMADR, 1'b0, 1'b0);
      go(B_MEMREAD, 1'b1, 1'b0);
      go(B_MEMWB, 1'b0, 1'b0);
      exp_ret++;
      go(B_FETCH, 1'b0, 1'b0);
      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL reset_mid: ctl=%b ret=%0d ill=%b be=%b required ctl=%b ret=%0d ill=%b be=%b",
                     o.ctl, o.ret, o.ill, o.be, e.ctl, e.ret, e.ill, e.be);
         end
      end
      obs_q.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      opcode    = 7'b0110011;
      exp_ret   = '0;
      exp_ill   = 1'b0;
      exp_be    = 1'b0;
      @(posedge clk);
      #1;
      test_reset;
      test_rtype;
      test_lw_wait;
      test_branch;
      test_jumps_itype_sw;
      test_illegal;
      test_timeout;
      test_reset_mid_access;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
